// File: rtl/instruction_fetch.sv
// Fetch stage of the 16-bit core: owns the PC, reads instruction memory and
// hands words to decode through a 2-entry valid/ready buffer.
module instruction_fetch #(
  parameter int unsigned     l            = 16,
  parameter logic [l-1:0]    RESET_PC     = '0,
  parameter int unsigned     HALT_ON_ZERO = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  output logic [l-1:0] Address,
  input  logic [l-1:0] Instruction,
  input  logic         Redirect,
  input  logic [l-1:0] RedirectTarget,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [l-1:0] OutInstruction,
  output logic [l-1:0] OutPC,
  output logic         Halted
);

  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 2;

  logic [l-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          head_q, head_d;
  logic          halted_q, halted_d;
  logic [l-1:0]  ent_pc_q    [DEPTH];
  logic [l-1:0]  ent_pc_d    [DEPTH];
  logic [l-1:0]  ent_instr_q [DEPTH];
  logic [l-1:0]  ent_instr_d [DEPTH];

  logic pop;
  logic fetch_en;
  logic zero_hit;
  logic push;
  logic tail;

  assign Address        = pc_q;
  assign OutValid       = (count_q != CW'(0));
  assign OutInstruction = ent_instr_q[head_q];
  assign OutPC          = ent_pc_q[head_q];
  assign Halted         = halted_q;

  assign pop      = OutValid && OutReady;
  assign fetch_en = !halted_q && !Redirect && ((count_q != CW'(2)) || pop);
  assign zero_hit = (HALT_ON_ZERO != 0) && (Instruction == '0);
  assign push     = fetch_en && !zero_hit;
  // Tail slot is head for count 0 or 2 (full slot is being freed by pop), else the other slot.
  assign tail     = head_q ^ count_q[0];

  // Next-state: redirect overrides halt detection, which overrides normal fetch.
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    head_d      = head_q;
    halted_d    = halted_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    if (Redirect) begin
      pc_d     = RedirectTarget;
      count_d  = CW'(0);
      head_d   = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (fetch_en && zero_hit) begin
        halted_d = 1'b1;
      end
      if (push) begin
        ent_pc_d[tail]    = pc_q;
        ent_instr_d[tail] = Instruction;
        pc_d              = pc_q + l'(1);
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      count_q  <= CW'(0);
      head_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      halted_q    <= halted_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the 16-bit core: owns the program counter, drives `InstructionMemory.Address` and samples its combinational `Instruction` output.
- Presents fetched words to decode through a valid/ready handshake, using a 2-entry buffer that absorbs decode stalls.
- Supports control-flow redirect and halts on the all-zero word that instruction memory returns for unmapped addresses.

## Interface
Parameters:
- `l`, 16, instruction and address width.
- `RESET_PC`, 0, PC value loaded on reset.
- `HALT_ON_ZERO`, 1, when 1 a fetched word of all zeros halts fetch.

Ports:
- `Clock`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Address`  out  l  current PC; connects to instruction memory `Address`.
- `Instruction`  in  l  memory read data for `Address`, valid in the same cycle.
- `Redirect`  in  1  load new PC and flush the buffer.
- `RedirectTarget`  in  l  new PC, used when `Redirect`=1.
- `OutValid`  out  1  buffer head is valid.
- `OutReady`  in  1  decode accepts the head this cycle.
- `OutInstruction`  out  l  instruction word at the buffer head.
- `OutPC`  out  l  address the head word was fetched from.
- `Halted`  out  1  fetch stopped on a zero word.

## Operation
State:
- PC register, l bits.
- 2-entry FIFO of {pc, instr}, with head pointer and 0..2 count.
- Halted flag.

Reset values:
- PC=`RESET_PC`, so `Address`=`RESET_PC`.
- count=0, `OutValid`=0, `OutInstruction`=0, `OutPC`=0, `Halted`=0.

Handshake and buffer:
- pop = `OutValid` & `OutReady`; the head is consumed at the clock edge.
- Fetch is enabled when `Halted`=0, `Redirect`=0, and (count<2 or pop).
- On fetch, push {PC, `Instruction`} and set PC <= PC+1, modulo 2^l. `0xFFFF` wraps to `0x0000`.
- Push and pop in the same cycle leave the count unchanged, including at count=2.
- Count=2 without pop: no fetch, PC and `Address` hold.
- Head outputs are stable while `OutValid`=1 and `OutReady`=0.

Halt:
- Applies when `HALT_ON_ZERO`=1, fetch is enabled and `Instruction`==0.
- The zero word is not pushed, PC holds, and `Halted` <= 1.
- Entries already buffered still drain normally.
- While halted no fetch occurs; `Halted` clears only on `Redirect` or `Reset`.
- With `HALT_ON_ZERO`=0, zero words are ordinary instructions.

Redirect, in one cycle:
- PC <= `RedirectTarget`, count <= 0, `Halted` <= 0.
- The memory word on `Instruction` that cycle is discarded; no push occurs.
- A pop in the same cycle still counts as a completed transfer, and the buffer is emptied regardless.

Priority:
1. Reset.
2. Redirect.
3. Halt detection.
4. Normal fetch/pop.

## Timing
- `Address` comes directly from the PC register; there is no combinational path from any input.
- `OutValid`, `OutInstruction` and `OutPC` come from registers. The only combinational input consumed is `Instruction`, sampled at the edge.
- Latency: the word at PC=N appears on `OutInstruction` with `OutPC`=N one cycle after `Address`=N, provided the buffer is not full.
- After reset deasserts, the first rising edge fetches `RESET_PC`, and `OutValid`=1 after that edge.
- Throughput is 1 word/cycle with `OutReady` held at 1.
- Redirect penalty: `OutValid`=0 for the edge after `Redirect`; the target word is valid after the following edge.
- `Halted` rises on the edge that samples the zero word.
- Asserting `Reset` at any point forces all reset values immediately, without waiting for a clock edge, and drops buffered entries.

## Test plan
Bench memory: 0:`0x6002`, 1:`0x6403`, 2:`0xE801`, 3:`0x4D7C`, all other addresses 0.

1. Reset, then `OutReady`=1 -> four consecutive transfers (`OutPC`,`OutInstruction`) = (0,`0x6002`), (1,`0x6403`), (2,`0xE801`), (3,`0x4D7C`); then `Halted`=1, `Address` holds at 4, `OutValid`=0 after the drain.
2. `OutReady`=0 from reset -> `Address` stops at 2, head holds (0,`0x6002`). Set `OutReady`=1 -> transfers 0,1,2,3 in order with no loss or duplicate.
3. Buffer full at PC=2, pulse `Redirect` with target 1 -> old entries dropped, `OutValid`=0 for one edge, next transfer is (1,`0x6403`).
4. While halted at PC=4, `Redirect` with target 0 -> `Halted`=0 after the edge, then (0,`0x6002`) delivered.
5. Assert `Reset` mid-stream between clock edges -> `OutValid`=0, `Address`=0 and `Halted`=0 immediately, with no clock edge.
6. `RESET_PC`=`0xFFFF`, `HALT_ON_ZERO`=0 -> transfers (`0xFFFF`,`0x0000`) then (`0x0000`,`0x6002`); PC wraps and no halt occurs.
